// File: rtl/control_ciclo.sv
// Washing-machine cycle controller: latches a paid program on a request edge in
// IDLE and steps through timed phases, pausing while the door is open.
module control_ciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic       SECADO,
    input  logic       LAVADO,
    input  logic       LAVADO_PESADO,
    input  logic       INSUFICIENTE,
    input  logic       PUERTA_ABIERTA,
    output logic       VALVULA,
    output logic       MOTOR,
    output logic       CENTRIFUGA,
    output logic       CALENTADOR,
    output logic       OCUPADO,
    output logic       TERMINADO,
    output logic       ALARMA,
    output logic [2:0] FASE
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LLENADO  = 3'd1,
        LAVA     = 3'd2,
        ENJUAGUE = 3'd3,
        CENTRIF  = 3'd4,
        SECA     = 3'd5,
        FIN      = 3'd6,
        ERROR    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PROG_NORMAL = 2'd0,
        PROG_HEAVY  = 2'd1,
        PROG_DRY    = 2'd2
    } prog_t;

    // Phase lengths in clk cycles; the counter is loaded with length-1.
    localparam logic [4:0] LEN_LLENADO        = 5'd4;
    localparam logic [4:0] LEN_LAVA_NORMAL    = 5'd8;
    localparam logic [4:0] LEN_LAVA_HEAVY     = 5'd16;
    localparam logic [4:0] LEN_ENJUAGUE_NORM  = 5'd4;
    localparam logic [4:0] LEN_ENJUAGUE_HEAVY = 5'd8;
    localparam logic [4:0] LEN_CENTRIF        = 5'd4;
    localparam logic [4:0] LEN_SECA           = 5'd6;
    localparam logic [4:0] LEN_FIN            = 5'd1;
    localparam logic [4:0] LEN_ERROR          = 5'd2;

    state_t      state, state_nx;
    prog_t       prog, prog_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [3:0]  req_now, req_sh, req_edge;
    logic        running, paused;

    function automatic logic [4:0] phase_load(input state_t s, input prog_t p);
        logic [4:0] len;
        case (s)
            LLENADO:  len = LEN_LLENADO;
            LAVA:     len = (p == PROG_HEAVY) ? LEN_LAVA_HEAVY : LEN_LAVA_NORMAL;
            ENJUAGUE: len = (p == PROG_HEAVY) ? LEN_ENJUAGUE_HEAVY : LEN_ENJUAGUE_NORM;
            CENTRIF:  len = LEN_CENTRIF;
            SECA:     len = LEN_SECA;
            FIN:      len = LEN_FIN;
            ERROR:    len = LEN_ERROR;
            default:  len = 5'd1;
        endcase
        return len - 5'd1;
    endfunction

    function automatic state_t phase_after(input state_t s);
        state_t n;
        case (s)
            LLENADO:  n = LAVA;
            LAVA:     n = ENJUAGUE;
            ENJUAGUE: n = CENTRIF;
            CENTRIF:  n = FIN;
            SECA:     n = FIN;
            default:  n = IDLE;
        endcase
        return n;
    endfunction

    // Bit order sets request priority: heavy, normal, dry, rejected.
    assign req_now  = {LAVADO_PESADO, LAVADO, SECADO, INSUFICIENTE};
    assign req_edge = req_now & ~req_sh;

    assign running = (state == LLENADO) || (state == LAVA) || (state == ENJUAGUE) ||
                     (state == CENTRIF) || (state == SECA);
    assign paused  = running && PUERTA_ABIERTA;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            prog   <= PROG_NORMAL;
            cnt    <= 5'd0;
            req_sh <= 4'b0000;
        end else begin
            state  <= state_nx;
            prog   <= prog_nx;
            cnt    <= cnt_nx;
            req_sh <= req_now;
        end
    end

    always_comb begin
        state_nx = state;
        prog_nx  = prog;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                // Edges seen outside IDLE are simply dropped by the shadow update.
                if (req_edge[3]) begin
                    state_nx = LLENADO;
                    prog_nx  = PROG_HEAVY;
                    cnt_nx   = phase_load(LLENADO, PROG_HEAVY);
                end else if (req_edge[2]) begin
                    state_nx = LLENADO;
                    prog_nx  = PROG_NORMAL;
                    cnt_nx   = phase_load(LLENADO, PROG_NORMAL);
                end else if (req_edge[1]) begin
                    state_nx = SECA;
                    prog_nx  = PROG_DRY;
                    cnt_nx   = phase_load(SECA, PROG_DRY);
                end else if (req_edge[0]) begin
                    state_nx = ERROR;
                    prog_nx  = PROG_NORMAL;
                    cnt_nx   = phase_load(ERROR, PROG_NORMAL);
                end
            end
            FIN, ERROR: begin
                if (cnt == 5'd0) begin
                    state_nx = IDLE;
                    prog_nx  = PROG_NORMAL;
                end else begin
                    cnt_nx = cnt - 5'd1;
                end
            end
            default: begin
                if (!paused) begin
                    if (cnt != 5'd0) begin
                        cnt_nx = cnt - 5'd1;
                    end else begin
                        state_nx = phase_after(state);
                        cnt_nx   = phase_load(phase_after(state), prog);
                    end
                end
            end
        endcase
    end

    // Moore decode; an open door only masks the actuators of a running phase.
    always_comb begin
        VALVULA    = 1'b0;
        MOTOR      = 1'b0;
        CENTRIFUGA = 1'b0;
        CALENTADOR = 1'b0;
        OCUPADO    = running;
        TERMINADO  = (state == FIN);
        ALARMA     = (state == ERROR);
        FASE       = state;
        if (!paused) begin
            VALVULA    = (state == LLENADO);
            MOTOR      = (state == LAVA) || (state == ENJUAGUE) || (state == SECA);
            CENTRIFUGA = (state == CENTRIF);
            CALENTADOR = ((state == LAVA) && (prog == PROG_HEAVY)) || (state == SECA);
        end
    end

endmodule

// File: tb/tb_control_ciclo.sv
// Scoreboard bench for control_ciclo: a phase-list reference model predicts every
// cycle's outputs; a monitor process compares them against the DUT.
module tb_control_ciclo;

    logic       clk = 1'b0;
    logic       reset;
    logic       SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE, PUERTA_ABIERTA;
    logic       VALVULA, MOTOR, CENTRIFUGA, CALENTADOR, OCUPADO, TERMINADO, ALARMA;
    logic [2:0] FASE;

    control_ciclo dut (
        .clk            (clk),
        .reset          (reset),
        .SECADO         (SECADO),
        .LAVADO         (LAVADO),
        .LAVADO_PESADO  (LAVADO_PESADO),
        .INSUFICIENTE   (INSUFICIENTE),
        .PUERTA_ABIERTA (PUERTA_ABIERTA),
        .VALVULA        (VALVULA),
        .MOTOR          (MOTOR),
        .CENTRIFUGA     (CENTRIFUGA),
        .CALENTADOR     (CALENTADOR),
        .OCUPADO        (OCUPADO),
        .TERMINADO      (TERMINADO),
        .ALARMA         (ALARMA),
        .FASE           (FASE)
    );

    always #5 clk = ~clk;

    typedef struct { int fase; int len; } ph_t;
    typedef struct { logic [9:0] v; int cyc; string tag; } exp_t;

    // Reference model: current phase code, cycles left in it, and the phases still to run.
    int         m_cur;
    int         m_left;
    bit         m_heavy;
    bit  [3:0]  m_shadow;
    ph_t        m_plan[$];

    exp_t       exp_q[$];
    event       sample_ev;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;

    function automatic void model_reset();
        m_cur    = 0;
        m_left   = 0;
        m_heavy  = 0;
        m_shadow = 4'b0000;
        m_plan.delete();
    endfunction

    function automatic void start_plan(input int kind);
        ph_t p;
        m_plan.delete();
        m_heavy = (kind == 3);
        case (kind)
            3: begin
                p.fase = 1; p.len = 4;  m_plan.push_back(p);
                p.fase = 2; p.len = 16; m_plan.push_back(p);
                p.fase = 3; p.len = 8;  m_plan.push_back(p);
                p.fase = 4; p.len = 4;  m_plan.push_back(p);
                p.fase = 6; p.len = 1;  m_plan.push_back(p);
            end
            2: begin
                p.fase = 1; p.len = 4;  m_plan.push_back(p);
                p.fase = 2; p.len = 8;  m_plan.push_back(p);
                p.fase = 3; p.len = 4;  m_plan.push_back(p);
                p.fase = 4; p.len = 4;  m_plan.push_back(p);
                p.fase = 6; p.len = 1;  m_plan.push_back(p);
            end
            1: begin
                p.fase = 5; p.len = 6;  m_plan.push_back(p);
                p.fase = 6; p.len = 1;  m_plan.push_back(p);
            end
            default: begin
                p.fase = 7; p.len = 2;  m_plan.push_back(p);
            end
        endcase
        p = m_plan.pop_front();
        m_cur  = p.fase;
        m_left = p.len;
    endfunction

    function automatic void model_clock(input logic [3:0] req, input logic door);
        logic [3:0] edges;
        ph_t        p;
        edges    = req & ~m_shadow;
        m_shadow = req;
        if (m_cur == 0) begin
            if (edges[3])      start_plan(3);
            else if (edges[2]) start_plan(2);
            else if (edges[1]) start_plan(1);
            else if (edges[0]) start_plan(0);
        end else if (!(m_cur <= 5 && door)) begin
            m_left--;
            if (m_left == 0) begin
                if (m_plan.size() > 0) begin
                    p = m_plan.pop_front();
                    m_cur  = p.fase;
                    m_left = p.len;
                end else begin
                    m_cur   = 0;
                    m_heavy = 0;
                end
            end
        end
    endfunction

    // Packed as {VALVULA, MOTOR, CENTRIFUGA, CALENTADOR, OCUPADO, TERMINADO, ALARMA, FASE}.
    function automatic logic [9:0] model_out(input logic door);
        bit run, act;
        logic [2:0] f;
        run = (m_cur >= 1 && m_cur <= 5);
        act = !(run && door);
        f   = 3'(m_cur);
        return {act && m_cur == 1,
                act && (m_cur == 2 || m_cur == 3 || m_cur == 5),
                act && m_cur == 4,
                act && ((m_cur == 2 && m_heavy) || m_cur == 5),
                run, m_cur == 6, m_cur == 7, f};
    endfunction

    task automatic push_expect(input string tag);
        exp_t e;
        e.v   = model_out(PUERTA_ABIERTA);
        e.cyc = cyc;
        e.tag = tag;
        exp_q.push_back(e);
        -> sample_ev;
    endtask

    // One clock cycle of stimulus; optionally pulse reset between clock edges.
    task automatic step(input logic [3:0] req, input logic door, input bit mid_reset);
        @(negedge clk);
        cyc++;
        {LAVADO_PESADO, LAVADO, SECADO, INSUFICIENTE} = req;
        PUERTA_ABIERTA = door;
        #1;
        push_expect("outputs");
        if (mid_reset) begin
            #1 reset = 1'b1;
            model_reset();
            #1;
            push_expect("async_reset");
            #1 reset = 1'b0;
        end
        model_clock(req, door);
    endtask

    task automatic hold(input logic [3:0] req, input int n);
        for (int i = 0; i < n; i++) step(req, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(sample_ev);
            act = {VALVULA, MOTOR, CENTRIFUGA, CALENTADOR, OCUPADO, TERMINADO, ALARMA, FASE};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow cycle %0d: got %b with nothing expected", cyc, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got %b (V M C H O T A FASE) required %b",
                             e.tag, e.cyc, act, e.v);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] req;
        logic       door;
        reset = 1'b1;
        {LAVADO_PESADO, LAVADO, SECADO, INSUFICIENTE, PUERTA_ABIERTA} = 5'b0;
        model_reset();
        #2;
        push_expect("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Normal wash, held request.
        hold(4'b0100, 24);
        hold(4'b0000, 2);
        // Heavy wash.
        hold(4'b1000, 36);
        hold(4'b0000, 2);
        // Dry, with a normal-wash edge arriving mid-program.
        hold(4'b0010, 3);
        hold(4'b0110, 8);
        hold(4'b0000, 3);
        // Rejected payment, then simultaneous normal + rejected edges.
        hold(4'b0001, 4);
        hold(4'b0000, 1);
        hold(4'b0101, 24);
        hold(4'b0000, 2);
        // Door opened for 3 cycles from the fifth LAVA cycle.
        for (int i = 0; i < 28; i++) step(4'b0100, (i >= 9 && i <= 11), 1'b0);
        hold(4'b0000, 2);
        // Door closing exactly as a phase count runs out.
        for (int i = 0; i < 28; i++) step(4'b0100, (i >= 4 && i <= 8), 1'b0);
        hold(4'b0000, 2);
        // Reset pulse during ENJUAGUE, then a fresh start.
        for (int i = 0; i < 16; i++) step(4'b0100, 1'b0, i == 15);
        hold(4'b0000, 3);
        hold(4'b0100, 3);
        hold(4'b0000, 22);
        // Reset released while a request is still held counts as an edge.
        step(4'b0010, 1'b0, 1'b1);
        hold(4'b0010, 9);
        hold(4'b0000, 2);
        // Door open in IDLE does not block a start.
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        hold(4'b0000, 24);

        // Randomized traffic.
        req  = 4'b0000;
        door = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 23) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 7) == 0) door = ~door;
            step(req, door, $urandom_range(0, 399) == 0);
        end

        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d expected samples never compared, required 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_ciclo.md
CONTROL_CICLO -- requirements
Module: control_ciclo

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single system clock, rising edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- SECADO, in, 1: payment stage selected dry-only program; level, sticky until reset.
- LAVADO, in, 1: payment stage selected normal wash; level, sticky.
- LAVADO_PESADO, in, 1: payment stage selected heavy wash; level, sticky.
- INSUFICIENTE, in, 1: payment stage rejected payment; level, sticky.
- PUERTA_ABIERTA, in, 1: door open; pauses a running phase.
- VALVULA, out, 1: water fill valve.
- MOTOR, out, 1: drum motor, slow.
- CENTRIFUGA, out, 1: spin motor.
- CALENTADOR, out, 1: heater.
- OCUPADO, out, 1: a program is running.
- TERMINADO, out, 1: one-cycle pulse at program end.
- ALARMA, out, 1: payment-rejected indication.
- FASE, out, 3: current state code.
REQ-002 The block SHALL use one clock. Reset is asynchronous and active-high; the ports are named clk and reset.

Function
REQ-003 The FSM states and their FASE codes SHALL be: IDLE=0, LLENADO=1, LAVA=2, ENJUAGUE=3, CENTRIF=4, SECA=5, FIN=6, ERROR=7.
REQ-004 Each of the four request inputs SHALL be registered each cycle; a request is its rising edge (input=1 and registered copy=0).
REQ-005 Requests SHALL be acted on only in IDLE; edges arriving in any other state are discarded and never queued.
REQ-006 If several rising edges occur in the same cycle, priority SHALL be LAVADO_PESADO > LAVADO > SECADO > INSUFICIENTE.
REQ-007 On the clock edge that detects a request in IDLE, the FSM SHALL enter its first state:
- LAVADO_PESADO or LAVADO -> LLENADO.
- SECADO -> SECA.
- INSUFICIENTE -> ERROR.
REQ-008 The program latched at start (normal, heavy, dry) SHALL be held in a register until return to IDLE.
REQ-009 Normal wash sequence and durations in clk cycles: LLENADO 4 -> LAVA 8 -> ENJUAGUE 4 -> CENTRIF 4 -> FIN.
REQ-010 Heavy wash SHALL use the normal sequence with LAVA 16 and ENJUAGUE 8.
REQ-011 Dry program sequence: SECA 6 -> FIN.
REQ-012 Phase timing SHALL use a 5-bit down-counter loaded with N-1 on phase entry; the phase exits when the count is 0 and is not paused, so each phase occupies exactly N unpaused cycles.
REQ-013 FIN SHALL last 1 cycle, then go to IDLE. ERROR SHALL last 2 cycles, then go to IDLE.
REQ-014 Outputs SHALL be Moore, decoded from the registered state:
- VALVULA=1 in LLENADO.
- MOTOR=1 in LAVA, ENJUAGUE and SECA.
- CENTRIFUGA=1 in CENTRIF.
- CALENTADOR=1 in LAVA (heavy program only) and SECA.
- OCUPADO=1 in states 1-5.
- TERMINADO=1 in FIN.
- ALARMA=1 in ERROR.
REQ-015 When PUERTA_ABIERTA=1 in states 1-5, the block SHALL:
- hold state and counter;
- force VALVULA, MOTOR, CENTRIFUGA and CALENTADOR to 0;
- keep OCUPADO=1 and FASE unchanged.
Normal operation resumes on the first cycle PUERTA_ABIERTA=0.
REQ-016 PUERTA_ABIERTA SHALL be ignored in IDLE, FIN and ERROR; a door-open IDLE still accepts requests.
REQ-017 If the door closes in the cycle where the count reaches 0, the phase SHALL exit on that cycle.

Reset
REQ-018 Asserting reset SHALL immediately, without waiting for clk, set:
- state to IDLE and the counter to 0;
- the program register to normal;
- the request shadow registers to 0;
- every output to 0 (FASE=0).
REQ-019 Reset asserted mid-program SHALL abort the program with no TERMINADO pulse.
REQ-020 After reset release, a request input still at 1 SHALL count as a new rising edge.

Verification
REQ-021 Normal wash: LAVADO 0->1 -> 20 cycles OCUPADO=1 with FASE 1(4),2(8),3(4),4(4); CALENTADOR=0 throughout; then TERMINADO=1 for 1 cycle; then FASE=0.
REQ-022 Heavy wash: LAVADO_PESADO 0->1 -> FASE 1(4),2(16),3(8),4(4); CALENTADOR=1 for the 16 LAVA cycles; TERMINADO on cycle 33.
REQ-023 Dry, then duplicate request: SECADO 0->1 -> FASE=5 for 6 cycles, MOTOR=CALENTADOR=1, then FIN; LAVADO rising during SECA -> ignored, FIN then IDLE with no new start.
REQ-024 Insufficient payment: INSUFICIENTE 0->1 -> FASE=7 and ALARMA=1 for 2 cycles, OCUPADO=0, then IDLE. Simultaneous LAVADO and INSUFICIENTE edges -> LLENADO (priority).
REQ-025 Door pause: PUERTA_ABIERTA=1 for 3 cycles at LAVA cycle 5 -> MOTOR=0 and FASE=2 held for those 3 cycles; LAVA lasts 11 cycles in total; TERMINADO on cycle 24.
REQ-026 Reset mid-operation: reset pulse in ENJUAGUE, between clk edges -> outputs 0 and FASE=0 immediately; no TERMINADO; a fresh LAVADO edge restarts at LLENADO.
